// File: rtl/button_pkg.sv
// Shared state type and board timing constants for push-button conditioning.
package button_pkg;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DB_PRESS   = 2'd1,
        S_HELD       = 2'd2,
        S_DB_RELEASE = 2'd3
    } btn_state_t;

    localparam int CLK_HZ    = 32'd100_000_000;
    localparam int DEB_5MS   = CLK_HZ / 32'd200;
    localparam int RPT_500MS = CLK_HZ / 32'd2;
    localparam int RPT_100MS = CLK_HZ / 32'd10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (b > a) ? b : a;
        m = (c > m) ? c : m;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous board input; both stages clear on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // First stage may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces one raw push-button into a clean level plus single-cycle press/release
// pulses, with optional hold-to-auto-repeat of the press pulse.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_5MS,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = RPT_500MS,
    parameter int REPEAT_PERIOD   = RPT_100MS
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press,
    output logic btn_release
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 32'sd1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 32'sd1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    btn_state_t       state_q;
    logic [CNT_W-1:0] deb_q;
    logic [CNT_W-1:0] rpt_q;
    logic             rpt_first_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             btn_s2;
    logic [CNT_W-1:0] rpt_lim_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s2)
    );

    // The first repeat waits the long delay; later ones use the shorter period.
    assign rpt_lim_s = rpt_first_q ? DLY_LAST : PER_LAST;

    // Debounce FSM with registered level and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            deb_q       <= '0;
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    deb_q <= '0;
                    if (btn_s2) begin
                        state_q <= S_DB_PRESS;
                    end
                end
                S_DB_PRESS: begin
                    if (!btn_s2) begin
                        state_q <= S_IDLE;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q     <= S_HELD;
                        deb_q       <= '0;
                        rpt_q       <= '0;
                        rpt_first_q <= 1'b1;
                        level_q     <= 1'b1;
                        press_q     <= 1'b1;
                    end else begin
                        deb_q <= deb_q + CNT_ONE;
                    end
                end
                S_HELD: begin
                    if (!btn_s2) begin
                        state_q <= S_DB_RELEASE;
                        deb_q   <= '0;
                    end else if (REPEAT_EN && (rpt_q == rpt_lim_s)) begin
                        press_q     <= 1'b1;
                        rpt_q       <= '0;
                        rpt_first_q <= 1'b0;
                    end else if (REPEAT_EN) begin
                        rpt_q <= rpt_q + CNT_ONE;
                    end else begin
                        rpt_q <= '0;
                    end
                end
                // rpt_q is left untouched here so a rejected release glitch resumes the repeat timing.
                S_DB_RELEASE: begin
                    if (btn_s2) begin
                        state_q <= S_HELD;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q   <= S_IDLE;
                        deb_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        deb_q <= deb_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    deb_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign press       = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: three instances (repeat on, repeat off, one-cycle debounce)
// driven by shared stimulus and checked each cycle against a run-length reference model.
module tb_button_conditioner;

    localparam int P_DLY = 10;
    localparam int P_PER = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic [2:0] lvl_o;
    logic [2:0] prs_o;
    logic [2:0] rel_o;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int cyc       = 0;

    // Per-instance reference state: accepted level, disagreement run length, held samples.
    int p_deb[3] = '{4, 4, 1};
    int p_rep[3] = '{1, 0, 0};
    int m_s1[3];
    int m_s2[3];
    int m_lvl[3];
    int m_run[3];
    int m_held[3];
    int m_prs[3];
    int m_rel[3];

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(P_DLY), .REPEAT_PERIOD(P_PER)) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(lvl_o[0]), .press(prs_o[0]), .btn_release(rel_o[0]));

    button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(P_DLY), .REPEAT_PERIOD(P_PER)) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(lvl_o[1]), .press(prs_o[1]), .btn_release(rel_o[1]));

    button_conditioner #(.DEBOUNCE_CYCLES(1), .REPEAT_EN(1'b0), .REPEAT_DELAY(P_DLY), .REPEAT_PERIOD(P_PER)) dut_c (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(lvl_o[2]), .press(prs_o[2]), .btn_release(rel_o[2]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b (failure #%0d)", tag, obs, exp, fail_cnt);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d (failure #%0d)", tag, obs, exp, fail_cnt);
        end
    endtask

    // Level flips once the synchronised input has disagreed with it for D+1 straight samples.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_run[k] = 0;
                m_held[k] = 0; m_prs[k] = 0; m_rel[k] = 0;
            end else begin
                m_prs[k] = 0;
                m_rel[k] = 0;
                if (m_s2[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == p_deb[k] + 1) begin
                        m_lvl[k] = m_s2[k];
                        m_run[k] = 0;
                        if (m_lvl[k] == 1) begin
                            m_prs[k]  = 1;
                            m_held[k] = 0;
                        end else begin
                            m_rel[k] = 1;
                        end
                    end
                end else begin
                    if (m_lvl[k] == 1 && m_run[k] == 0 && p_rep[k] == 1) begin
                        m_held[k]++;
                        if (m_held[k] == P_DLY ||
                            (m_held[k] > P_DLY && (m_held[k] - P_DLY) % P_PER == 0))
                            m_prs[k] = 1;
                    end
                    m_run[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = int'(btn_in);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cyc%0d u%0d level", cyc, k), lvl_o[k], m_lvl[k] != 0);
            chk($sformatf("cyc%0d u%0d press", cyc, k), prs_o[k], m_prs[k] != 0);
            chk($sformatf("cyc%0d u%0d release", cyc, k), rel_o[k], m_rel[k] != 0);
        end
    endtask

    task automatic chk_quiet(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s u%0d level", tag, k), lvl_o[k], 1'b0);
            chk($sformatf("%s u%0d press", tag, k), prs_o[k], 1'b0);
            chk($sformatf("%s u%0d release", tag, k), rel_o[k], 1'b0);
        end
    endtask

    initial begin
        int na;
        int nb;
        int nc_p;
        int nc_r;
        rst    = 1'b1;
        btn_in = 1'b0;
        tick();
        tick();
        chk_quiet("reset");

        // Press and long hold: single press without repeat, repeat train with it.
        rst    = 1'b0;
        btn_in = 1'b1;
        na     = 0;
        nb     = 0;
        for (int e = 0; e <= 36; e++) begin
            tick();
            chk($sformatf("hold e%0d press_b", e), prs_o[1], e == 6);
            chk($sformatf("hold e%0d level_b", e), lvl_o[1], e >= 6);
            chk($sformatf("hold e%0d rel_b", e), rel_o[1], 1'b0);
            chk($sformatf("hold e%0d press_a", e), prs_o[0], e == 6 || (e >= 16 && (e - 16) % 3 == 0));
            chk($sformatf("hold e%0d press_c", e), prs_o[2], e == 3);
            if (prs_o[0]) na++;
            if (prs_o[1]) nb++;
        end
        chk_int("repeat pulse count", na, 8);
        chk_int("no-repeat pulse count", nb, 1);

        // Release with a one-cycle glitch high during release debounce.
        for (int f = 0; f <= 11; f++) begin
            btn_in = (f == 1);
            tick();
            chk($sformatf("glitch f%0d rel_b", f), rel_o[1], f == 8);
            chk($sformatf("glitch f%0d level_b", f), lvl_o[1], f < 8);
            chk($sformatf("glitch f%0d press_b", f), prs_o[1], 1'b0);
            chk($sformatf("glitch f%0d rel_c", f), rel_o[2], f == 5);
        end

        // Bounce x5, then stable high.
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1;
            tick();
            chk($sformatf("bounce%0d hi press_b", i), prs_o[1], 1'b0);
            chk($sformatf("bounce%0d hi press_c", i), prs_o[2], 1'b0);
            btn_in = 1'b0;
            tick();
            chk($sformatf("bounce%0d lo press_b", i), prs_o[1], 1'b0);
            chk($sformatf("bounce%0d lo press_c", i), prs_o[2], 1'b0);
        end
        btn_in = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            tick();
            chk($sformatf("settle e%0d press_b", e), prs_o[1], e == 6);
            chk($sformatf("settle e%0d press_c", e), prs_o[2], e == 3);
        end

        // Reset in press debounce, then in held state, with the button kept down.
        btn_in = 1'b0;
        repeat (12) tick();
        btn_in = 1'b1;
        for (int e = 0; e <= 3; e++) begin
            tick();
            chk($sformatf("predb e%0d level_b", e), lvl_o[1], 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            rst = 1'b1;
            tick();
            chk_quiet($sformatf("rst%0d", r));
            rst = 1'b0;
            for (int e = 0; e <= 9; e++) begin
                tick();
                chk($sformatf("rst%0d e%0d press_b", r, e), prs_o[1], e == 6);
                chk($sformatf("rst%0d e%0d press_c", r, e), prs_o[2], e == 3);
                chk($sformatf("rst%0d e%0d rel_b", r, e), rel_o[1], 1'b0);
            end
        end

        // Two-cycle tap: accepted only by the one-cycle debounce instance.
        btn_in = 1'b0;
        repeat (12) tick();
        nb   = 0;
        nc_p = 0;
        nc_r = 0;
        for (int g = 0; g < 12; g++) begin
            btn_in = (g < 2);
            tick();
            if (prs_o[1]) nb++;
            if (prs_o[2]) nc_p++;
            if (rel_o[2]) nc_r++;
        end
        chk_int("tap press_b count", nb, 0);
        chk_int("tap press_c count", nc_p, 1);
        chk_int("tap release_c count", nc_r, 1);

        // Random segments of mixed length with occasional resets.
        while (cyc < 1800) begin
            logic val;
            int   len;
            val = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) begin
                btn_in = val;
                rst    = ($urandom_range(0, 99) == 0);
                tick();
            end
        end
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
